// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and zero-cycle lookup.
// Define BRANCH_PREDICTOR_STATS_EN to add saturating branch/mispredict statistics outputs.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        prediction_taken,
    output logic [31:0] prediction_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_predicted_taken
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_branch_count,
    output logic [31:0] stat_mispredict_count
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]      fetch_tag;
    logic                  fetch_hit;

    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    logic                  entry_we;
    logic [1:0]            entry_ctr_d;
    logic [31:0]           entry_target_d;

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    always_comb begin
        fetch_idx         = fetch_pc[INDEX_BITS+1:2];
        fetch_tag         = fetch_pc[31:INDEX_BITS+2];
        fetch_hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        prediction_taken  = fetch_hit && ctr_q[fetch_idx][1];
        prediction_target = prediction_taken ? target_q[fetch_idx] : (fetch_pc + 32'd4);
    end

    always_comb begin
        upd_idx        = update_pc[INDEX_BITS+1:2];
        upd_tag        = update_pc[31:INDEX_BITS+2];
        upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        entry_we       = 1'b0;
        entry_ctr_d    = ctr_q[upd_idx];
        entry_target_d = target_q[upd_idx];
        if (update_valid) begin
            if (upd_hit) begin
                entry_we = 1'b1;
                if (update_taken) begin
                    entry_target_d = update_target;
                    if (ctr_q[upd_idx] != 2'b11) entry_ctr_d = ctr_q[upd_idx] + 2'd1;
                end else begin
                    if (ctr_q[upd_idx] != 2'b00) entry_ctr_d = ctr_q[upd_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Allocate only on taken branches; a not-taken miss keeps the resident entry.
                entry_we       = 1'b1;
                entry_ctr_d    = 2'b10;
                entry_target_d = update_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (entry_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= entry_target_d;
            ctr_q[upd_idx]    <= entry_ctr_d;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update_valid) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
            if ((update_predicted_taken != update_taken) && (mispred_cnt_q != 32'hFFFF_FFFF))
                mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign stat_branch_count     = branch_cnt_q;
    assign stat_mispredict_count = mispred_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], update_pc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], update_pc[1:0], update_predicted_taken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table through a scoreboard queue, plus
// hand-written reset sequences and (when built with the stats macro) statistics checks.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        prediction_taken;
    logic [31:0] prediction_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_predicted_taken;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_branch_count;
    logic [31:0] stat_mispredict_count;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .fetch_pc               (fetch_pc),
        .prediction_taken       (prediction_taken),
        .prediction_target      (prediction_target),
        .update_valid           (update_valid),
        .update_pc              (update_pc),
        .update_taken           (update_taken),
        .update_target          (update_target),
        .update_predicted_taken (update_predicted_taken)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .stat_branch_count      (stat_branch_count),
        .stat_mispredict_count  (stat_mispredict_count)
`endif
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upred;
        logic [31:0] fpc;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        int          id;
    } sb_t;

    vec_t vecs[$];
    vec_t svecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_br   = 0;
    int   exp_mp   = 0;

    function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic upred, logic [31:0] fpc, logic et, logic [31:0] etgt);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upred = upred;
        v.fpc = fpc; v.exp_taken = et; v.exp_target = etgt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        update_valid           = 1'b0;
        update_pc              = 32'h0;
        update_taken           = 1'b0;
        update_target          = 32'h0;
        update_predicted_taken = 1'b0;
    endtask

    // Drive one vector after the edge, push its expectation, compare mid-cycle.
    task automatic step(input vec_t v, input int id);
        sb_t e;
        @(posedge clk); #1;
        update_valid           = v.uv;
        update_pc              = v.upc;
        update_taken           = v.ut;
        update_target          = v.utgt;
        update_predicted_taken = v.upred;
        fetch_pc               = v.fpc;
        sb.push_back('{v.exp_taken, v.exp_target, id});
        if (v.uv) begin
            exp_br++;
            if (v.upred != v.ut) exp_mp++;
        end
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("vec%0d taken", e.id), {31'b0, prediction_taken}, {31'b0, e.taken});
        check($sformatf("vec%0d target", e.id), prediction_target, e.target);
    endtask

    task automatic reset_with_update(input logic [31:0] upc, input logic [31:0] utgt);
        @(posedge clk); #1;
        rst_n         = 1'b0;
        update_valid  = 1'b1;
        update_pc     = upc;
        update_taken  = 1'b1;
        update_target = utgt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
        exp_br = 0;
        exp_mp = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        fetch_pc = 32'h0;
        idle_inputs();

        // uv, upc, ut, utgt, upred, fetch, exp_taken, exp_target
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'hFFFF_FFFC, 0, 32'h0000_0000));
        vecs.push_back(mk(1, 32'h100,  1, 32'h80,  0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 1, 32'h0000_0080));
        vecs.push_back(mk(1, 32'h100,  0, 32'h0,   1, 32'h0000_0100, 1, 32'h0000_0080));
        vecs.push_back(mk(1, 32'h100,  0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(1, 32'h100,  0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(1, 32'h100,  0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(1, 32'h100,  1, 32'h80,  0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(1, 32'h100,  1, 32'h84,  0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 1, 32'h0000_0084));
        vecs.push_back(mk(1, 32'h100,  1, 32'h84,  1, 32'h0000_0100, 1, 32'h0000_0084));
        vecs.push_back(mk(1, 32'h100,  1, 32'h84,  1, 32'h0000_0100, 1, 32'h0000_0084));
        vecs.push_back(mk(1, 32'h100,  0, 32'h0,   1, 32'h0000_0100, 1, 32'h0000_0084));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 1, 32'h0000_0084));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0200, 0, 32'h0000_0204));
        vecs.push_back(mk(1, 32'h200,  0, 32'h0,   0, 32'h0000_0200, 0, 32'h0000_0204));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 1, 32'h0000_0084));
        vecs.push_back(mk(1, 32'h200,  1, 32'h300, 0, 32'h0000_0200, 0, 32'h0000_0204));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0200, 1, 32'h0000_0300));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h100,  1, 32'h500, 0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0100, 0, 32'h0000_0104));
        vecs.push_back(mk(1, 32'h1004, 1, 32'h2000,0, 32'h0000_1004, 0, 32'h0000_1008));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_1004, 1, 32'h0000_2000));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 32'h0000_0200, 1, 32'h0000_0300));

        // Post-reset sequence: five updates, entries 0 and 2 mispredicted.
        svecs.push_back(mk(1, 32'h40,  1, 32'h80,  0, 32'h0000_0040, 0, 32'h0000_0044));
        svecs.push_back(mk(1, 32'h40,  1, 32'h80,  1, 32'h0000_0040, 1, 32'h0000_0080));
        svecs.push_back(mk(1, 32'h40,  0, 32'h0,   1, 32'h0000_0040, 1, 32'h0000_0080));
        svecs.push_back(mk(1, 32'h44,  0, 32'h0,   0, 32'h0000_0044, 0, 32'h0000_0048));
        svecs.push_back(mk(1, 32'h44,  0, 32'h0,   0, 32'h0000_0040, 1, 32'h0000_0080));
        svecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0000_0040, 1, 32'h0000_0080));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Reset mid-operation with a concurrent taken update: nothing learned may survive.
        reset_with_update(32'h0000_0300, 32'h0000_0700);
        step(mk(0, 32'h0, 0, 32'h0, 0, 32'h0000_0300, 0, 32'h0000_0304), 100);
        step(mk(0, 32'h0, 0, 32'h0, 0, 32'h0000_1004, 0, 32'h0000_1008), 101);
        step(mk(0, 32'h0, 0, 32'h0, 0, 32'h0000_0200, 0, 32'h0000_0204), 102);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_branch_after_reset", stat_branch_count, 32'd0);
        check("stat_mispredict_after_reset", stat_mispredict_count, 32'd0);
`endif

        reset_with_update(32'h0000_0040, 32'h0000_0900);
        for (int i = 0; i < svecs.size(); i++) step(svecs[i], 200 + i);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_branch_count", stat_branch_count, 32'(exp_br));
        check("stat_mispredict_count", stat_mispredict_count, 32'(exp_mp));
        check("stat_branch_literal", stat_branch_count, 32'd5);
        check("stat_mispredict_literal", stat_mispredict_count, 32'd2);
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
